// File: rtl/pixel_frame_loader.sv
// Ping-pong frame buffer between the pixel stream and the hazard-detector NN.
// One bank fills from the stream while the other is held stable for the NN.
module pixel_frame_loader #(
  parameter int NUM_PIXELS = 208,
  parameter int PIX_W      = 8,
  parameter int ERR_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PIX_W-1:0]            pix_data,
  input  logic                        pix_valid,
  input  logic                        pix_sof,
  output logic                        pix_ready,
  output logic                        nn_start,
  input  logic                        nn_done,
  output logic [NUM_PIXELS*PIX_W-1:0] frame_pixels,
  output logic                        busy,
  output logic                        sync_err,
  output logic [ERR_W-1:0]            err_count
);

  localparam int IDX_W = $clog2(NUM_PIXELS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    L_IDLE,
    L_RUN,
    L_DRAIN
  } l_state_t;

  l_state_t         state, state_nxt;
  logic [1:0]       bank_full, full_nxt;
  logic             wr_bank, rd_bank;
  logic [IDX_W-1:0] wr_idx, wr_addr;
  logic             xfer, we, fill, err, rel;

  logic [PIX_W-1:0] mem [2][NUM_PIXELS];

  assign pix_ready = rst & ~bank_full[wr_bank];
  assign xfer      = pix_valid & pix_ready;
  assign err       = xfer & (pix_sof ? (wr_idx != '0) : (wr_idx == '0));
  assign we        = xfer & (pix_sof | (wr_idx != '0));
  assign wr_addr   = pix_sof ? '0 : wr_idx;
  assign fill      = xfer & ~pix_sof & (wr_idx == LAST);

  assign nn_start  = (state == L_RUN);
  assign busy      = (state != L_IDLE);

  always_comb begin
    state_nxt = state;
    rel       = 1'b0;
    unique case (state)
      L_IDLE:
        if (bank_full[rd_bank] && !nn_done)
          state_nxt = L_RUN;
      L_RUN:
        if (nn_done)
          state_nxt = L_DRAIN;
      L_DRAIN:
        if (!nn_done) begin
          state_nxt = L_IDLE;
          rel       = 1'b1;
        end
      default:
        state_nxt = L_IDLE;
    endcase
  end

  // A write never targets a full bank, so release and fill hit different banks
  always_comb begin
    full_nxt = bank_full;
    if (rel)
      full_nxt[rd_bank] = 1'b0;
    if (fill)
      full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= L_IDLE;
      rd_bank   <= 1'b0;
      bank_full <= '0;
    end else begin
      state     <= state_nxt;
      bank_full <= full_nxt;
      if (rel)
        rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      sync_err  <= 1'b0;
      err_count <= '0;
    end else begin
      sync_err <= err;
      if (err && (err_count != '1))
        err_count <= err_count + 1'b1;
      if (xfer) begin
        if (pix_sof)
          wr_idx <= IDX_W'(1);
        else if (fill) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else if (wr_idx != '0)
          wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  // Pixel storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (we)
      mem[wr_bank][wr_addr] <= pix_data;
  end

  for (genvar g = 0; g < NUM_PIXELS; g++) begin : g_out
    assign frame_pixels[g*PIX_W +: PIX_W] = mem[rd_bank][g];
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench for pixel_frame_loader: framing, ping-pong launch,
// stalls, sync errors, saturation and mid-run reset.
module tb_pixel_frame_loader;

  localparam int NP = 208;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_ready;
  logic          nn_start;
  logic          nn_done;
  logic [NP*8-1:0] frame_pixels;
  logic          busy;
  logic          sync_err;
  logic [7:0]    err_count;

  int n_chk = 0;
  int n_err = 0;

  pixel_frame_loader dut (
    .clk          (clk),
    .rst          (rst),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_ready    (pix_ready),
    .nn_start     (nn_start),
    .nn_done      (nn_done),
    .frame_pixels (frame_pixels),
    .busy         (busy),
    .sync_err     (sync_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int k, input int i);
    case (k)
      0: return 8'(i);
      1: return 8'(i) ^ 8'hA5;
      2: return 8'(255 - i);
      3: return 8'(i + 3);
      5: return 8'(i + 7);
      6: return 8'(i + 50);
      default: return 8'(i) ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [7:0] px(input int i);
    return frame_pixels[i*8 +: 8];
  endfunction

  task automatic send_pix(input logic [7:0] d, input logic sof);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    step();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input int k, input int from, input int to);
    for (int i = from; i < to; i++)
      send_pix(pat(k, i), i == 0);
  endtask

  task automatic release_nn();
    nn_done = 1'b1;
    step();
    nn_done = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b0;
    pix_data  = '0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    nn_done   = 1'b0;
    step();
    step();
    chk("rst_ready", pix_ready, 0);
    chk("rst_start", nn_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_serr", sync_err, 0);
    chk("rst_ecnt", err_count, 0);
    rst = 1'b1;
    #1;
    chk("ready_up", pix_ready, 1);

    // first frame and launch latency
    send_frame(0, 0, NP);
    chk("lat_e0", nn_start, 0);
    step();
    chk("lat_e1", nn_start, 1);
    chk("busy_run", busy, 1);
    chk("a_px0", px(0), 8'd0);
    chk("a_px100", px(100), 8'd100);
    chk("a_px207", px(207), 8'd207);

    // NN model: done 50 cycles after start, drops 2 cycles after start falls
    repeat (49) step();
    chk("hold_start", nn_start, 1);
    nn_done = 1'b1;
    step();
    chk("start_fall", nn_start, 0);
    chk("busy_drain", busy, 1);
    step();
    step();
    nn_done = 1'b0;
    step();
    chk("busy_rel", busy, 0);
    chk("rd_bank1", dut.rd_bank, 1);
    step();
    chk("no_relaunch", nn_start, 0);

    // three frames with the NN stalled
    send_frame(1, 0, NP);
    send_frame(2, 0, NP);
    chk("b_start", nn_start, 1);
    chk("both_full", pix_ready, 0);
    chk("b_px5", px(5), 8'h05 ^ 8'hA5);
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    pix_data  = pat(3, 0);
    repeat (3) step();
    chk("stall_ready", pix_ready, 0);
    chk("b_px5_hold", px(5), 8'h05 ^ 8'hA5);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    release_nn();
    chk("ready_rel", pix_ready, 1);
    step();
    chk("c_start", nn_start, 1);
    chk("c_px7", px(7), 8'd248);
    send_frame(3, 0, NP);
    chk("c_stable", px(7), 8'd248);
    chk("d_full", pix_ready, 0);
    release_nn();
    step();
    chk("d_start", nn_start, 1);
    chk("d_px9", px(9), 8'd12);
    release_nn();

    // sof in the middle of a frame
    for (int i = 0; i < 100; i++)
      send_pix(8'hEE, i == 0);
    chk("mid_noerr", sync_err, 0);
    send_pix(pat(5, 0), 1'b1);
    chk("mid_serr", sync_err, 1);
    chk("mid_ecnt", err_count, 1);
    send_pix(pat(5, 1), 1'b0);
    chk("mid_pulse", sync_err, 0);
    send_frame(5, 2, NP);
    step();
    chk("f_start", nn_start, 1);
    chk("f_px0", px(0), 8'd7);
    chk("f_px99", px(99), 8'd106);
    chk("f_px150", px(150), 8'd157);
    release_nn();
    repeat (5) step();
    chk("f_once", nn_start, 0);

    // pixels without sof, then saturation
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send_pix(8'h11, 1'b0);
      chk("nosof_serr", sync_err, 1);
      chk("nosof_ecnt", err_count, 32'(i));
    end
    step();
    chk("nosof_idle", sync_err, 0);
    chk("nosof_nolaunch", nn_start, 0);
    for (int i = 6; i <= 300; i++) begin
      send_pix(8'h22, 1'b0);
      if (i == 254)
        chk("ecnt_254", err_count, 254);
      if (i == 256)
        chk("ecnt_sat", err_count, 255);
    end
    chk("ecnt_300", err_count, 255);
    chk("serr_sat", sync_err, 1);

    // reset during L_RUN with a partial frame
    send_frame(6, 0, NP);
    step();
    chk("g_start", nn_start, 1);
    send_frame(7, 0, 37);
    chk("widx37", dut.wr_idx, 37);
    rst = 1'b0;
    step();
    chk("mr_start", nn_start, 0);
    chk("mr_ready", pix_ready, 0);
    chk("mr_widx", dut.wr_idx, 0);
    chk("mr_busy", busy, 0);
    rst = 1'b1;
    #1;
    chk("mr_ready1", pix_ready, 1);

    // stale done holds off launch
    nn_done = 1'b1;
    send_frame(7, 0, NP);
    repeat (3) step();
    chk("stale_hold", nn_start, 0);
    nn_done = 1'b0;
    step();
    chk("h_start", nn_start, 1);
    chk("h_px0", px(0), 8'h3C);
    chk("h_px200", px(200), 8'hF4);
    release_nn();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
